// File: rtl/cpu5_decode_stage_pkg.sv
// cpu5_decode_stage_pkg: ALU/branch/imm encodings, opcodes and control bundle (CPU5_RV32M_EN widens aluop for M ops)
package cpu5_decode_stage_pkg;
`ifdef CPU5_RV32M_EN
  localparam int ALU_OP_SIZE = 5;
`else
  localparam int ALU_OP_SIZE = 4;
`endif
  localparam int BRANCHTYPE_SIZE = 3;
  localparam int IMMTYPE_SIZE = 3;
  typedef logic [ALU_OP_SIZE-1:0] aluop_t;
  typedef logic [BRANCHTYPE_SIZE-1:0] brtype_t;
  typedef logic [IMMTYPE_SIZE-1:0] immtype_t;
  localparam aluop_t ALU_ADD  = aluop_t'(0);
  localparam aluop_t ALU_SUB  = aluop_t'(1);
  localparam aluop_t ALU_SLL  = aluop_t'(2);
  localparam aluop_t ALU_SLT  = aluop_t'(3);
  localparam aluop_t ALU_SLTU = aluop_t'(4);
  localparam aluop_t ALU_XOR  = aluop_t'(5);
  localparam aluop_t ALU_SRL  = aluop_t'(6);
  localparam aluop_t ALU_SRA  = aluop_t'(7);
  localparam aluop_t ALU_OR   = aluop_t'(8);
  localparam aluop_t ALU_AND  = aluop_t'(9);
`ifdef CPU5_RV32M_EN
  localparam aluop_t ALU_MUL    = aluop_t'(16);
  localparam aluop_t ALU_MULH   = aluop_t'(17);
  localparam aluop_t ALU_MULHSU = aluop_t'(18);
  localparam aluop_t ALU_MULHU  = aluop_t'(19);
  localparam aluop_t ALU_DIV    = aluop_t'(20);
  localparam aluop_t ALU_DIVU   = aluop_t'(21);
  localparam aluop_t ALU_REM    = aluop_t'(22);
  localparam aluop_t ALU_REMU   = aluop_t'(23);
`endif
  localparam brtype_t BR_NONE = 3'd0;
  localparam brtype_t BR_BEQ  = 3'd1;
  localparam brtype_t BR_BNE  = 3'd2;
  localparam brtype_t BR_BLT  = 3'd3;
  localparam brtype_t BR_BGE  = 3'd4;
  localparam brtype_t BR_BLTU = 3'd5;
  localparam brtype_t BR_BGEU = 3'd6;
  localparam immtype_t IMM_R = 3'd0;
  localparam immtype_t IMM_I = 3'd1;
  localparam immtype_t IMM_S = 3'd2;
  localparam immtype_t IMM_B = 3'd3;
  localparam immtype_t IMM_U = 3'd4;
  localparam immtype_t IMM_J = 3'd5;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  typedef struct packed {
    logic     memtoreg;
    logic     memwrite;
    brtype_t  branchtype;
    logic     alusrc;
    logic     regwrite;
    logic     jump;
    aluop_t   aluop;
    immtype_t immtype;
  } ctrl_t;
  localparam int CTRL_W = $bits(ctrl_t);
  function automatic aluop_t f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/cpu5_decode_stage_if.sv
// cpu5_decode_stage_if: fetch-side (if_*) and execute-side (id_*) handshake bundle; master = neighbours, slave = stage
interface cpu5_decode_stage_if
  import cpu5_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 2
) ();
  logic                       if_valid;
  logic                       if_ready;
  logic [XLEN-1:0]            if_pc;
  logic [31:0]                if_instr;
  logic                       id_valid;
  logic                       id_ready;
  logic [XLEN-1:0]            id_pc;
  logic [31:0]                id_instr;
  logic                       id_memtoreg;
  logic                       id_memwrite;
  brtype_t                    id_branchtype;
  logic                       id_alusrc;
  logic                       id_regwrite;
  logic                       id_jump;
  aluop_t                     id_aluop;
  immtype_t                   id_immtype;
  logic                       id_illegal;
  logic [$clog2(DEPTH+1)-1:0] id_count;
  modport master (
    output if_valid, if_pc, if_instr, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_memtoreg, id_memwrite, id_branchtype,
           id_alusrc, id_regwrite, id_jump, id_aluop, id_immtype, id_illegal, id_count
  );
  modport slave (
    input  if_valid, if_pc, if_instr, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_memtoreg, id_memwrite, id_branchtype,
           id_alusrc, id_regwrite, id_jump, id_aluop, id_immtype, id_illegal, id_count
  );
endinterface

// File: rtl/cpu5_decode_stage_logic.sv
// cpu5_decode_logic: combinational RV32I instr -> {ctrl, illegal}; CPU5_RV32M_EN adds OP funct7=0000001 M ops
module cpu5_decode_logic
  import cpu5_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       ok;
  ctrl_t      c;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  always_comb begin
    c = '0;
    ok = 1'b0;
    case (op)
      OPC_LUI, OPC_AUIPC: begin
        ok = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.immtype = IMM_U;
      end
      OPC_JAL: begin
        ok = 1'b1;
        c.jump = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.immtype = IMM_J;
      end
      OPC_JALR: begin
        ok = f3 == 3'd0;
        c.jump = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.immtype = IMM_I;
      end
      OPC_BRANCH: begin
        ok = f3[2:1] != 2'b01;
        c.branchtype = f3[2] ? f3 - 3'd1 : f3 + 3'd1;
        c.aluop = !f3[2] ? ALU_SUB : f3[1] ? ALU_SLTU : ALU_SLT;
        c.immtype = IMM_B;
      end
      OPC_LOAD: begin
        ok = f3 != 3'd3 && f3[2:1] != 2'b11;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.immtype = IMM_I;
      end
      OPC_STORE: begin
        ok = f3 < 3'd3;
        c.memwrite = 1'b1;
        c.alusrc = 1'b1;
        c.immtype = IMM_S;
      end
      OPC_OPIMM: begin
        ok = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        c.aluop = f3_alu(f3, f3 == 3'd5 && f7[5]);
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.immtype = IMM_I;
      end
      OPC_OP: begin
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        c.aluop = f3_alu(f3, f7[5]);
        c.regwrite = 1'b1;
        c.immtype = IMM_R;
`ifdef CPU5_RV32M_EN
        if (f7 == 7'h01) begin
          ok = 1'b1;
          c.aluop = ALU_MUL | aluop_t'(f3);
        end
`endif
      end
      OPC_FENCE: ok = f3 == 3'd0;
      default: ok = 1'b0;
    endcase
    c.regwrite = c.regwrite && instr[11:7] != 5'd0;
    illegal = !ok || instr == 32'd0;
    ctrl = illegal ? '0 : c;
  end
endmodule

// File: rtl/cpu5_decode_stage.sv
// cpu5_decode_stage: decode-at-enqueue into a DEPTH-entry FIFO between fetch (bus.if_*) and execute (bus.id_*), CPU5_RV32M_EN selects M decode
module cpu5_decode_stage
  import cpu5_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  input logic                flush,
  cpu5_decode_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    ctrl_t           ctrl;
    logic            illegal;
  } entry_t;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  ctrl_t         dec_ctrl;
  logic          dec_illegal, push, pop;
  cpu5_decode_logic u_dec (
    .instr(bus.if_instr),
    .ctrl(dec_ctrl),
    .illegal(dec_illegal)
  );
  assign bus.if_ready = count < CW'(DEPTH) || bus.id_ready;
  assign push = bus.if_valid && bus.if_ready && !flush;
  assign pop = bus.id_valid && bus.id_ready && !flush;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= '{pc: bus.if_pc, instr: bus.if_instr, ctrl: dec_ctrl, illegal: dec_illegal};
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rd_ptr];
  assign bus.id_valid = count != '0;
  assign bus.id_count = count;
  assign bus.id_pc = head.pc;
  assign bus.id_instr = head.instr;
  assign bus.id_memtoreg = head.ctrl.memtoreg;
  assign bus.id_memwrite = head.ctrl.memwrite;
  assign bus.id_branchtype = head.ctrl.branchtype;
  assign bus.id_alusrc = head.ctrl.alusrc;
  assign bus.id_regwrite = head.ctrl.regwrite;
  assign bus.id_jump = head.ctrl.jump;
  assign bus.id_aluop = head.ctrl.aluop;
  assign bus.id_immtype = head.ctrl.immtype;
  assign bus.id_illegal = head.illegal;
endmodule

// File: tb/tb_cpu5_decode_stage.sv
// tb_cpu5_decode_stage: scoreboard bench for cpu5_decode_stage decode, FIFO ordering, backpressure and flush
module tb_cpu5_decode_stage;
  import cpu5_decode_stage_pkg::*;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0050A223;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LUI  = 32'h123453B7;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4030D213;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_ONES = 32'hFFFFFFFF;
  localparam logic [31:0] I_ZERO = 32'h00000000;
  localparam logic [31:0] I_BADS = 32'h40309213;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] STREAM [8] = '{I_ADDI, I_LW, I_SW, I_JAL, I_LUI, I_SUB, I_SRAI, I_BADS};
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memtoreg;
    logic        memwrite;
    brtype_t     br;
    logic        alusrc;
    logic        regwrite;
    logic        jump;
    aluop_t      aluop;
    immtype_t    imm;
    logic        illegal;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  cpu5_decode_stage_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();
  cpu5_decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic exp_t expect_for(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e = '0;
    e.pc = pc;
    e.instr = instr;
    case (instr)
      I_ADDI: begin e.alusrc = 1'b1; e.regwrite = 1'b1; e.aluop = ALU_ADD; e.imm = IMM_I; end
      I_LW:   begin e.memtoreg = 1'b1; e.alusrc = 1'b1; e.regwrite = 1'b1; e.imm = IMM_I; end
      I_SW:   begin e.memwrite = 1'b1; e.alusrc = 1'b1; e.imm = IMM_S; end
      I_JAL:  begin e.jump = 1'b1; e.regwrite = 1'b1; e.alusrc = 1'b1; e.imm = IMM_J; end
      I_LUI:  begin e.regwrite = 1'b1; e.alusrc = 1'b1; e.imm = IMM_U; end
      I_SUB:  begin e.regwrite = 1'b1; e.aluop = ALU_SUB; e.imm = IMM_R; end
      I_SRAI: begin e.regwrite = 1'b1; e.alusrc = 1'b1; e.aluop = ALU_SRA; e.imm = IMM_I; end
      I_BLTU: begin e.br = BR_BLTU; e.aluop = ALU_SLTU; e.imm = IMM_B; end
      I_NOP:  begin e.alusrc = 1'b1; e.imm = IMM_I; end
`ifdef CPU5_RV32M_EN
      I_MUL:  begin e.regwrite = 1'b1; e.aluop = ALU_MUL; e.imm = IMM_R; end
`else
      I_MUL:  e.illegal = 1'b1;
`endif
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction
  function automatic exp_t observed();
    return {bus.id_pc, bus.id_instr, bus.id_memtoreg, bus.id_memwrite, bus.id_branchtype, bus.id_alusrc,
            bus.id_regwrite, bus.id_jump, bus.id_aluop, bus.id_immtype, bus.id_illegal};
  endfunction
  task automatic step(output logic acc);
    exp_t e;
    @(negedge clk);
    if (bus.id_valid === 1'b1 && bus.id_ready && !flush && !reset) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: got pc=%h instr=%h, required no output", bus.id_pc, bus.id_instr);
      end else begin
        e = q.pop_front();
        if (observed() !== e) begin
          bad++;
          $display("FAIL scoreboard_entry: got %h, required %h", observed(), e);
        end
      end
    end
    acc = bus.if_valid === 1'b1 && bus.if_ready === 1'b1 && !flush && !reset;
    if (acc) q.push_back(expect_for(bus.if_pc, bus.if_instr));
    @(posedge clk);
    #1;
  endtask
  task automatic cycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask
  task automatic send(input logic [31:0] pc, input logic [31:0] instr);
    logic acc;
    int n = 0;
    bus.if_valid = 1'b1;
    bus.if_pc = pc;
    bus.if_instr = instr;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 50);
    bus.if_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: pc=%h not accepted, required accept within 50 cycles", pc);
    end
  endtask
  task automatic drain();
    logic acc;
    int n = 0;
    bus.id_ready = 1'b1;
    while (bus.id_count !== '0 && n < 50) begin
      step(acc);
      n++;
    end
    total++;
    if (bus.id_count !== '0 || q.size() != 0) begin
      bad++;
      $display("FAIL drain: count=%0d pending=%0d, required 0 and 0", bus.id_count, q.size());
    end
  endtask
  task automatic test_reset();
    bus.if_valid = 1'b0;
    bus.if_pc = '0;
    bus.if_instr = '0;
    bus.id_ready = 1'b0;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    total++;
    if (bus.if_ready !== 1'b1 || bus.id_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: if_ready=%b id_valid=%b, required 1 0", bus.if_ready, bus.id_valid);
    end
    total++;
    if (bus.id_count !== '0) begin
      bad++;
      $display("FAIL reset_count: got %0d, required 0", bus.id_count);
    end
    total++;
    if (observed() !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", observed());
    end
  endtask
  task automatic test_addi();
    logic acc;
    bus.id_ready = 1'b0;
    send(32'h100, I_ADDI);
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_count !== CW'(1)) begin
      bad++;
      $display("FAIL addi_latency: id_valid=%b count=%0d, required 1 1", bus.id_valid, bus.id_count);
    end
    total++;
    if ({bus.id_alusrc, bus.id_regwrite, bus.id_aluop, bus.id_immtype} !== {1'b1, 1'b1, ALU_ADD, IMM_I}) begin
      bad++;
      $display("FAIL addi_ctrl: alusrc=%b regwrite=%b aluop=%0d imm=%0d, required 1 1 %0d %0d",
               bus.id_alusrc, bus.id_regwrite, bus.id_aluop, bus.id_immtype, ALU_ADD, IMM_I);
    end
    bus.id_ready = 1'b1;
    step(acc);
    total++;
    if (bus.id_valid !== 1'b0) begin
      bad++;
      $display("FAIL addi_pop: id_valid=%b, required 0", bus.id_valid);
    end
  endtask
  task automatic test_full();
    logic [31:0] hold_pc;
    bus.id_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(32'(32'h200 + 4 * i), STREAM[i]);
    total++;
    if (bus.if_ready !== 1'b0 || bus.id_count !== FULL) begin
      bad++;
      $display("FAIL full: if_ready=%b count=%0d, required 0 %0d", bus.if_ready, bus.id_count, DEPTH);
    end
    hold_pc = bus.id_pc;
    cycles(2);
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== hold_pc) begin
      bad++;
      $display("FAIL stall_hold: id_valid=%b pc=%h, required 1 %h", bus.id_valid, bus.id_pc, hold_pc);
    end
    bus.id_ready = 1'b1;
    #1;
    total++;
    if (bus.if_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_ready_passthrough: if_ready=%b, required 1", bus.if_ready);
    end
    send(32'(32'h200 + 4 * DEPTH), STREAM[DEPTH]);
    total++;
    if (bus.id_count !== FULL) begin
      bad++;
      $display("FAIL full_push_pop: count=%0d, required %0d", bus.id_count, DEPTH);
    end
    drain();
  endtask
  task automatic test_back_to_back();
    bus.id_ready = 1'b1;
    send(32'h300, I_BLTU);
    total++;
    if (bus.id_branchtype !== BR_BLTU || bus.id_aluop !== ALU_SLTU) begin
      bad++;
      $display("FAIL bltu_ctrl: branchtype=%0d aluop=%0d, required %0d %0d",
               bus.id_branchtype, bus.id_aluop, BR_BLTU, ALU_SLTU);
    end
    send(32'h304, I_NOP);
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_instr !== I_NOP || bus.id_regwrite !== 1'b0) begin
      bad++;
      $display("FAIL nop_x0: valid=%b instr=%h regwrite=%b, required 1 %h 0",
               bus.id_valid, bus.id_instr, bus.id_regwrite, I_NOP);
    end
    for (int i = 0; i < 24; i++) begin
      bus.id_ready = bus.id_count == FULL ? 1'b1 : 1'($urandom_range(0, 1));
      send(32'(32'h400 + 4 * i), STREAM[i % 8]);
    end
    drain();
  endtask
  task automatic test_flush();
    logic acc;
    bus.id_ready = 1'b0;
    send(32'h500, I_ADDI);
    send(32'h504, I_LW);
    total++;
    if (bus.id_count !== CW'(2)) begin
      bad++;
      $display("FAIL flush_prefill: count=%0d, required 2", bus.id_count);
    end
    bus.if_valid = 1'b1;
    bus.if_pc = 32'h508;
    bus.if_instr = I_LUI;
    flush = 1'b1;
    step(acc);
    flush = 1'b0;
    bus.if_valid = 1'b0;
    q.delete();
    total++;
    if (bus.id_valid !== 1'b0 || bus.id_count !== '0) begin
      bad++;
      $display("FAIL flush_clear: id_valid=%b count=%0d, required 0 0", bus.id_valid, bus.id_count);
    end
    bus.id_ready = 1'b1;
    cycles(3);
    total++;
    if (bus.id_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_ghost: id_valid=%b pc=%h, required 0", bus.id_valid, bus.id_pc);
    end
    send(32'h50C, I_SW);
    drain();
  endtask
  task automatic test_illegal();
    bus.id_ready = 1'b0;
    send(32'h600, I_ONES);
    total++;
    if ({bus.id_illegal, bus.id_memwrite, bus.id_regwrite, bus.id_jump, bus.id_branchtype} !== {4'b1000, BR_NONE}) begin
      bad++;
      $display("FAIL illegal_ones: illegal=%b mw=%b rw=%b j=%b br=%0d, required 1 0 0 0 0",
               bus.id_illegal, bus.id_memwrite, bus.id_regwrite, bus.id_jump, bus.id_branchtype);
    end
    bus.id_ready = 1'b1;
    send(32'h604, I_ZERO);
    total++;
    if ({bus.id_illegal, bus.id_memwrite, bus.id_regwrite, bus.id_jump, bus.id_branchtype} !== {4'b1000, BR_NONE}) begin
      bad++;
      $display("FAIL illegal_zero: illegal=%b mw=%b rw=%b j=%b br=%0d, required 1 0 0 0 0",
               bus.id_illegal, bus.id_memwrite, bus.id_regwrite, bus.id_jump, bus.id_branchtype);
    end
    send(32'h608, I_BADS);
    drain();
  endtask
  task automatic test_mul();
    exp_t e;
    e = expect_for(32'h700, I_MUL);
    bus.id_ready = 1'b0;
    send(32'h700, I_MUL);
    total++;
    if (bus.id_illegal !== e.illegal || bus.id_aluop !== e.aluop) begin
      bad++;
      $display("FAIL mul_decode: illegal=%b aluop=%0d, required %b %0d", bus.id_illegal, bus.id_aluop, e.illegal, e.aluop);
    end
    drain();
  endtask
  initial begin
    test_reset();
    test_addi();
    test_full();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
